// File: rtl/nn_pkg.sv
// nn_pkg
// Shared definitions for the network front end.
//   cond_state_t    : warm-up state of input_conditioner (FILL, RUN)
//   DEFAULT_W       : default sample width
//   RECEPTIVE_FIELD : samples of history the network needs before its
//                     caches are valid; input_conditioner's WARMUP defaults
//                     from it
package nn_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } cond_state_t;

  localparam int DEFAULT_W       = 16;
  localparam int RECEPTIVE_FIELD = 64;

endpackage

// File: rtl/input_conditioner_dc_blocker.sv
// dc_blocker
// One-pole DC blocker used by input_conditioner when the macro
// INPUT_CONDITIONER_DC_BLOCK_EN is defined; the module does not exist
// otherwise.
//   y = x - x_prev + y_prev - (y_prev >>> DC_K), saturated to W bits.
// Ports:
//   sample_clk : sample-rate clock, rising edge
//   rst        : asynchronous active-high reset
//   clear      : synchronous clear of the filter history (channel unplugged)
//   x_in       : W-bit signed input sample
//   y_out      : W-bit signed registered output
`ifdef INPUT_CONDITIONER_DC_BLOCK_EN
module dc_blocker
  import nn_pkg::*;
#(
  parameter int W    = DEFAULT_W,
  parameter int DC_K = 8
) (
  input  logic                sample_clk,
  input  logic                rst,
  input  logic                clear,
  input  logic signed [W-1:0] x_in,
  output logic signed [W-1:0] y_out
);

  localparam int AW = W + 4;
  localparam logic signed [AW-1:0] SAT_MAX = {5'b00000, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {5'b11111, {(W-1){1'b0}}};

  logic signed [W-1:0]  x_prev;
  logic signed [W-1:0]  y_q;
  logic signed [W-1:0]  y_leak;
  logic signed [AW-1:0] acc;
  logic signed [W-1:0]  y_next;

  // Four guard bits hold the worst-case sum of the four W-bit terms, so the
  // accumulator never wraps before saturation is applied.
  always_comb begin
    y_leak = y_q >>> DC_K;
    acc    = {{4{x_in[W-1]}}, x_in}
           - {{4{x_prev[W-1]}}, x_prev}
           + {{4{y_q[W-1]}}, y_q}
           - {{4{y_leak[W-1]}}, y_leak};
    if (acc > SAT_MAX) begin
      y_next = SAT_MAX[W-1:0];
    end else if (acc < SAT_MIN) begin
      y_next = SAT_MIN[W-1:0];
    end else begin
      y_next = acc[W-1:0];
    end
  end

  // Filter history is forgotten whenever the channel is unplugged so a
  // re-plug starts from a clean state.
  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      x_prev <= '0;
      y_q    <= '0;
    end else if (clear) begin
      x_prev <= '0;
      y_q    <= '0;
    end else begin
      x_prev <= x_in;
      y_q    <= y_next;
    end
  end

  assign y_out = y_q;

endmodule
`endif

// File: rtl/input_conditioner.sv
// input_conditioner
// Per-sample front end feeding the network: registers four codec inputs,
// applies an arithmetic pre-shift, gates each channel on a debounced
// jack-presence bit, and raises ready once the network's receptive field
// holds WARMUP samples since the last jack change or reset.
// Optional feature: define INPUT_CONDITIONER_DC_BLOCK_EN to replace the pure
// shift stage with a per-channel dc_blocker (same latency).
// Ports:
//   sample_clk                : sample-rate clock, rising edge
//   rst                       : asynchronous active-high reset
//   sample_in0..sample_in3    : W-bit signed raw codec samples
//   jack[7:0]                 : raw jack detect, bits [3:0] used
//   cond_out0..cond_out3      : W-bit signed conditioned samples
//   jack_stable[3:0]          : debounced presence of channels 0..3
//   ready                     : network history valid
module input_conditioner
  import nn_pkg::*;
#(
  parameter int W        = DEFAULT_W,
  parameter int SHIFT    = 2,
  parameter int DEBOUNCE = 64,
  parameter int WARMUP   = RECEPTIVE_FIELD,
  parameter int DC_K     = 8
) (
  input  logic                sample_clk,
  input  logic                rst,
  input  logic signed [W-1:0] sample_in0,
  input  logic signed [W-1:0] sample_in1,
  input  logic signed [W-1:0] sample_in2,
  input  logic signed [W-1:0] sample_in3,
  input  logic [7:0]          jack,
  output logic signed [W-1:0] cond_out0,
  output logic signed [W-1:0] cond_out1,
  output logic signed [W-1:0] cond_out2,
  output logic signed [W-1:0] cond_out3,
  output logic [3:0]          jack_stable,
  output logic                ready
);

  localparam int NCH = 4;
  localparam int DW  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int WW  = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE - 1);
  localparam logic [WW-1:0] WCNT_LAST = WW'(WARMUP - 1);

  logic signed [W-1:0] s_in    [NCH];
  logic signed [W-1:0] s1      [NCH];
  logic signed [W-1:0] shifted [NCH];
  logic signed [W-1:0] s2      [NCH];
  logic signed [W-1:0] cond_q  [NCH];

  logic [DW-1:0]  dcnt [NCH];
  logic [NCH-1:0] commit;
  logic           any_commit;

  cond_state_t    state;
  logic [WW-1:0]  wcnt;

  logic unused_jack_hi;
  assign unused_jack_hi = ^jack[7:4];

  assign s_in[0] = sample_in0;
  assign s_in[1] = sample_in1;
  assign s_in[2] = sample_in2;
  assign s_in[3] = sample_in3;

  // Stage 1: capture the raw codec samples.
  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NCH; n++) s1[n] <= '0;
    end else begin
      for (int n = 0; n < NCH; n++) s1[n] <= s_in[n];
    end
  end

  // Arithmetic shift keeps the sign and can only shrink magnitude, so it
  // never overflows.
  always_comb begin
    for (int n = 0; n < NCH; n++) shifted[n] = s1[n] >>> SHIFT;
  end

  // Stage 2: pure shift, or shift followed by the DC blocker.
`ifdef INPUT_CONDITIONER_DC_BLOCK_EN
  for (genvar g = 0; g < NCH; g++) begin : g_dc
    dc_blocker #(
      .W    (W),
      .DC_K (DC_K)
    ) u_dc (
      .sample_clk (sample_clk),
      .rst        (rst),
      .clear      (~jack_stable[g]),
      .x_in       (shifted[g]),
      .y_out      (s2[g])
    );
  end
`else
  localparam int UNUSED_DC_K = DC_K;

  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NCH; n++) s2[n] <= '0;
    end else begin
      for (int n = 0; n < NCH; n++) s2[n] <= shifted[n];
    end
  end
`endif

  // Stage 3: gate on the debounced presence bit as it stood before this
  // edge, so the output mutes one edge after a commit.
  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NCH; n++) cond_q[n] <= '0;
    end else begin
      for (int n = 0; n < NCH; n++) cond_q[n] <= jack_stable[n] ? s2[n] : '0;
    end
  end

  assign cond_out0 = cond_q[0];
  assign cond_out1 = cond_q[1];
  assign cond_out2 = cond_q[2];
  assign cond_out3 = cond_q[3];

  // A commit happens on the DEBOUNCE-th consecutive edge the raw bit
  // disagrees with the committed one.
  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      commit[n] = (jack[n] != jack_stable[n]) && (dcnt[n] == DCNT_LAST);
    end
    any_commit = |commit;
  end

  // Debounce counters: any agreement resets the run, so glitches shorter
  // than DEBOUNCE edges never reach jack_stable.
  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      jack_stable <= '0;
      for (int n = 0; n < NCH; n++) dcnt[n] <= '0;
    end else begin
      for (int n = 0; n < NCH; n++) begin
        if (commit[n]) begin
          jack_stable[n] <= jack[n];
          dcnt[n]        <= '0;
        end else if (jack[n] == jack_stable[n]) begin
          dcnt[n] <= '0;
        end else begin
          dcnt[n] <= dcnt[n] + DW'(1);
        end
      end
    end
  end

  // Warm-up FSM: any commit restarts the fill and takes priority over the
  // FILL terminal count; simultaneous commits are one refill.
  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      wcnt  <= '0;
      ready <= 1'b0;
    end else if (any_commit) begin
      state <= FILL;
      wcnt  <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (wcnt == WCNT_LAST) begin
            state <= RUN;
            wcnt  <= '0;
            ready <= 1'b1;
          end else begin
            wcnt  <= wcnt + WW'(1);
            ready <= 1'b0;
          end
        end
        RUN: begin
          ready <= 1'b1;
        end
        default: begin
          state <= FILL;
          wcnt  <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
